line_window_cache: RTL and testbench

// Parametrised line cache for the image accelerator. On start, reads one frame from data memory
// in raster order. For each word it presents a vertical column on a valid/ready stream:
// the current word plus the same-column words of the previous NUM_LINES rows.

---
 rtl/line_window_cache.sv | 206 ++++++++++++++++++++
 tb/tb_line_window_cache.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/line_window_cache.sv
// line_window_cache: streams a frame from data memory in raster order and
// presents each word as a vertical column with the same-column words of the
// previous NUM_LINES rows. Also owns a shared memory write path with a
// wrapping write pointer.
module line_window_cache #(
    parameter int unsigned WIDTH       = 352,
    parameter int unsigned HEIGHT      = 288,
    parameter int unsigned NUM_LINES   = 2,
    parameter int unsigned MEM_LATENCY = 2,
    parameter int unsigned RD_BASE     = 0,
    parameter int unsigned WR_BASE     = WIDTH * HEIGHT / 4,
    parameter int unsigned BYTE_SWAP   = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic [15:0]                     mem_addr,
    output logic                            mem_en,
    output logic                            mem_we,
    output logic [31:0]                     mem_di,
    input  logic [31:0]                     mem_do,
    input  logic                            wr_en,
    input  logic [31:0]                     wr_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [32*(NUM_LINES+1)-1:0]     out_col,
    output logic [$clog2(NUM_LINES+1)-1:0]  out_rows,
    output logic [15:0]                     out_x,
    output logic [15:0]                     out_y
);

    localparam int unsigned ROW_WORDS   = WIDTH / 4;
    localparam int unsigned FRAME_WORDS = ROW_WORDS * HEIGHT;
    localparam int unsigned DEPTH       = MEM_LATENCY + 1;
    localparam int unsigned PW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW          = $clog2(DEPTH + 1);
    localparam int unsigned XW          = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
    localparam int unsigned RW          = $clog2(NUM_LINES + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      credits;
    logic [15:0]        rd_cnt;
    logic [15:0]        wr_ptr;
    logic [MEM_LATENCY:0] rd_pipe;
    logic [31:0]        fifo_mem [DEPTH];
    logic [PW-1:0]      fifo_wp, fifo_rp;
    logic [CW-1:0]      fifo_cnt;
    logic [31:0]        line_mem [NUM_LINES][ROW_WORDS];
    logic [XW-1:0]      x_idx;
    logic               start_ok, rd_issue, last_rd, hs, last_col, fifo_push, row_wrap;

    function automatic logic [31:0] swap32(input logic [31:0] d);
        return (BYTE_SWAP != 0) ? {d[7:0], d[15:8], d[23:16], d[31:24]} : d;
    endfunction

    assign start_ok  = (state_q == S_IDLE) && start;
    assign rd_issue  = (state_q == S_RUN) && (credits != '0) && !wr_en;
    assign last_rd   = (rd_cnt == 16'(FRAME_WORDS - 1));
    assign out_valid = (fifo_cnt != '0);
    assign hs        = out_valid && out_ready;
    assign row_wrap  = (out_x == 16'(ROW_WORDS - 1));
    assign last_col  = row_wrap && (out_y == 16'(HEIGHT - 1));
    assign fifo_push = rd_pipe[MEM_LATENCY];
    assign x_idx     = out_x[XW-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and status outputs
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN: begin
                busy = 1'b1;
                if (rd_issue && last_rd) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (hs && last_col) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Memory port: a write request always wins the port over a read
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_di   <= '0;
        end else if (wr_en) begin
            mem_en   <= 1'b1;
            mem_we   <= 1'b1;
            mem_addr <= wr_ptr;
            mem_di   <= swap32(wr_data);
        end else if (rd_issue) begin
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= 16'(RD_BASE) + rd_cnt;
        end else begin
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
        end
    end

    // Write pointer, wrapping after one frame's worth of writes
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            wr_ptr <= 16'(WR_BASE);
        end else if (wr_en) begin
            if (wr_ptr == 16'(WR_BASE + FRAME_WORDS - 1)) wr_ptr <= 16'(WR_BASE);
            else                                          wr_ptr <= wr_ptr + 16'd1;
        end
    end

    // Read counter and credits; a credit covers one return-buffer slot
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt  <= '0;
            credits <= CW'(DEPTH);
        end else begin
            if (start_ok)      rd_cnt <= '0;
            else if (rd_issue) rd_cnt <= rd_cnt + 16'd1;
            credits <= credits + CW'(hs) - CW'(rd_issue);
        end
    end

    // Read-return tracker: stage i is high i cycles after mem_en went out
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe[0] <= rd_issue;
            for (int unsigned i = 1; i <= MEM_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    // Return buffer storage
    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[fifo_wp] <= swap32(mem_do);
    end

    // Return buffer pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_wp  <= '0;
            fifo_rp  <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_push) fifo_wp <= (fifo_wp == PW'(DEPTH - 1)) ? '0 : fifo_wp + 1'b1;
            if (hs)        fifo_rp <= (fifo_rp == PW'(DEPTH - 1)) ? '0 : fifo_rp + 1'b1;
            fifo_cnt <= fifo_cnt + CW'(fifo_push) - CW'(hs);
        end
    end

    // Line store: shift the accepted column down one row
    always_ff @(posedge clk) begin
        if (hs) begin
            line_mem[0][x_idx] <= fifo_mem[fifo_rp];
            for (int unsigned k = 1; k < NUM_LINES; k++)
                line_mem[k][x_idx] <= line_mem[k-1][x_idx];
        end
    end

    // Output position and count of valid older rows
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            out_x    <= '0;
            out_y    <= '0;
            out_rows <= '0;
        end else if (hs) begin
            if (row_wrap) begin
                out_x <= '0;
                out_y <= out_y + 16'd1;
                if (out_y >= 16'(NUM_LINES - 1)) out_rows <= RW'(NUM_LINES);
                else                             out_rows <= RW'(out_y + 16'd1);
            end else begin
                out_x <= out_x + 16'd1;
            end
        end
    end

    // Column assembly; older rows beyond out_rows are masked to zero
    always_comb begin
        out_col        = '0;
        out_col[31:0]  = fifo_mem[fifo_rp];
        for (int unsigned k = 1; k <= NUM_LINES; k++)
            if (k <= 32'(out_rows)) out_col[32*k +: 32] = line_mem[k-1][x_idx];
    end

endmodule

// File: tb/tb_line_window_cache.sv
module tb_line_window_cache;

  localparam int unsigned W = 16, H = 3, NL = 2, ROWW = 4, FW = 12, WRB = 12;

  logic        clk = 1'b0;
  logic        rst, start, busy, done;
  logic [15:0] mem_addr;
  logic        mem_en, mem_we;
  logic [31:0] mem_di, mem_do, wr_data;
  logic        wr_en, out_valid, out_ready;
  logic [95:0] out_col;
  logic [1:0]  out_rows;
  logic [15:0] out_x, out_y;

  line_window_cache #(
    .WIDTH(W), .HEIGHT(H), .NUM_LINES(NL), .MEM_LATENCY(1),
    .RD_BASE(0), .WR_BASE(WRB), .BYTE_SWAP(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we), .mem_di(mem_di),
    .mem_do(mem_do), .wr_en(wr_en), .wr_data(wr_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col),
    .out_rows(out_rows), .out_x(out_x), .out_y(out_y)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_do <= (mem_en && !mem_we) ? {8'h00, mem_addr, 8'h00} : 32'hDEADBEEF;

  typedef struct { logic [95:0] col; logic [15:0] x, y; logic [1:0] rows; } col_t;
  typedef struct { logic [15:0] addr; logic [31:0] data; } wr_t;

  col_t col_q[$];
  wr_t  wr_q[$];
  int   checks = 0, failures = 0;
  int   frame_hs, done_cnt, rd_seen;
  logic [15:0] exp_raddr, tb_wptr;
  logic wr_pend = 1'b0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sw(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic logic [31:0] word(input int unsigned n);
    return {8'h00, 16'(n), 8'h00};
  endfunction

  task automatic monitor();
    col_t e;
    wr_t  w;
    if (!rst) begin
      if (wr_pend || mem_we) begin
        chk("mem_we", mem_we, wr_pend);
        chk("mem_en_wr", mem_en, 1'b1);
        if (wr_pend && wr_q.size() > 0) begin
          w = wr_q.pop_front();
          chk("wr_addr", mem_addr, w.addr);
          chk("wr_data", mem_di, w.data);
        end
      end else if (mem_en) begin
        rd_seen++;
        chk("rd_addr", mem_addr, exp_raddr);
        exp_raddr++;
      end
      if (out_valid && out_ready) begin
        if (col_q.size() == 0) begin
          chk("col_unexpected", out_valid, 1'b0);
        end else begin
          e = col_q.pop_front();
          chk("col_data", out_col, e.col);
          chk("col_x", out_x, e.x);
          chk("col_y", out_y, e.y);
          chk("col_rows", out_rows, e.rows);
          frame_hs++;
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_after_last", frame_hs, 12);
      end
    end
    wr_pend = wr_en;
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_mem_di", mem_di, 32'h0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_rows", out_rows, 2'd0);
    chk("rst_out_x", out_x, 16'h0);
    chk("rst_out_y", out_y, 16'h0);
  endtask

  task automatic start_frame();
    col_t c;
    for (int unsigned y = 0; y < H; y++)
      for (int unsigned x = 0; x < ROWW; x++) begin
        c.col = '0;
        c.col[31:0] = sw(word(y*ROWW + x));
        for (int unsigned k = 1; k <= NL; k++)
          if (k <= y) c.col[32*k +: 32] = sw(word(y*ROWW + x - ROWW*k));
        c.x = 16'(x);
        c.y = 16'(y);
        c.rows = (y > NL) ? 2'(NL) : 2'(y);
        col_q.push_back(c);
      end
    exp_raddr = '0;
    tb_wptr   = 16'(WRB);
    frame_hs  = 0;
    done_cnt  = 0;
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic finish_frame();
    int unsigned n;
    n = 0;
    while (done_cnt == 0 && n < 400) begin
      cycle();
      n++;
    end
    chk("done_timeout", n < 400, 1'b1);
    repeat (3) cycle();
    chk("done_once", done_cnt, 1);
    chk("cols_left", col_q.size(), 0);
    chk("idle_busy", busy, 1'b0);
    chk("reads_total", exp_raddr, 16'(FW));
  endtask

  task automatic do_writes(input int unsigned n);
    wr_t w;
    for (int unsigned i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = $urandom;
      w.addr  = tb_wptr;
      w.data  = sw(wr_data);
      wr_q.push_back(w);
      tb_wptr = (tb_wptr == 16'(WRB + FW - 1)) ? 16'(WRB) : tb_wptr + 16'd1;
      cycle();
    end
    wr_en = 1'b0;
  endtask

  initial begin
    int unsigned n;
    rst = 1'b1; start = 1'b0; wr_en = 1'b0; wr_data = '0; out_ready = 1'b1;
    exp_raddr = '0; tb_wptr = 16'(WRB); frame_hs = 0; done_cnt = 0; rd_seen = 0;
    repeat (3) cycle();
    check_reset_state();
    rst = 1'b0;
    cycle();

    do_writes(13);
    repeat (2) cycle();
    chk("wr_q_empty", wr_q.size(), 0);

    start_frame();
    finish_frame();

    out_ready = 1'b0;
    start_frame();
    rd_seen = 0;
    n = 0;
    while (!out_valid && n < 50) begin
      cycle();
      n++;
    end
    chk("first_valid", out_valid, 1'b1);
    for (int unsigned i = 0; i < 20; i++) begin
      cycle();
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_col", out_col, col_q[0].col);
      chk("stall_x", out_x, 16'h0);
    end
    chk("stall_reads", rd_seen, 2);
    out_ready = 1'b1;
    finish_frame();

    start_frame();
    repeat (3) cycle();
    do_writes(5);
    finish_frame();
    chk("wr_q_empty2", wr_q.size(), 0);

    start_frame();
    repeat (8) cycle();
    rst = 1'b1;
    cycle();
    check_reset_state();
    rst = 1'b0;
    col_q.delete();
    wr_q.delete();
    start_frame();
    finish_frame();

    start_frame();
    repeat (5) cycle();
    start = 1'b1;
    cycle();
    start = 1'b0;
    finish_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
